// File: rtl/decode_issue_stage_pkg.sv
// Shared definitions for the decode/issue stage.
//   - opcode values of the 16-bit RISC ISA
//   - FSM state encoding (S_DECODE = 0, S_IMM = 1)
//   - decoded control bundle and the helpers that build it from an opcode
// Field layout (baseline OPC_W=5, RA_W=3): opc=inst[15:11], rd=inst[10:8],
// rs1=inst[7:5], rs2=inst[4:2]. Wider/narrower parameters shift the fields
// down from the opcode; the offsets are derived in the top module.
package decode_issue_stage_pkg;

  localparam int unsigned OPC_NOP    = 0;
  localparam int unsigned OPC_ALU_LO = 1;
  localparam int unsigned OPC_ALU_HI = 15;
  localparam int unsigned OPC_LDM    = 16;
  localparam int unsigned OPC_IADD   = 17;
  localparam int unsigned OPC_LDD    = 18;
  localparam int unsigned OPC_STD    = 19;

  typedef enum logic {
    S_DECODE = 1'b0,
    S_IMM    = 1'b1
  } state_e;

  typedef struct packed {
    logic alu_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic two_word;
    logic uses_rs1;
    logic uses_rs2;
  } ctrl_t;

  function automatic logic is_alu(input int unsigned opc);
    return (opc >= OPC_ALU_LO) && (opc <= OPC_ALU_HI);
  endfunction

  function automatic logic is_two_word(input int unsigned opc);
    return (opc >= OPC_LDM) && (opc <= OPC_STD);
  endfunction

  function automatic logic uses_rs1(input int unsigned opc);
    return is_alu(opc) || (opc == OPC_IADD) || (opc == OPC_LDD) || (opc == OPC_STD);
  endfunction

  function automatic logic uses_rs2(input int unsigned opc);
    return is_alu(opc) || (opc == OPC_STD);
  endfunction

  // Unlisted opcodes fall through with every bit clear, i.e. they issue as NOP.
  function automatic ctrl_t decode(input int unsigned opc);
    ctrl_t c;
    c          = '0;
    c.two_word = is_two_word(opc);
    c.uses_rs1 = uses_rs1(opc);
    c.uses_rs2 = uses_rs2(opc);
    if (is_alu(opc)) begin
      c.alu_to_reg = 1'b1;
      c.reg_write  = 1'b1;
    end else begin
      case (opc)
        OPC_LDM, OPC_IADD: begin
          c.alu_to_reg = 1'b1;
          c.reg_write  = 1'b1;
        end
        OPC_LDD: begin
          c.mem_read  = 1'b1;
          c.reg_write = 1'b1;
        end
        OPC_STD: c.mem_write = 1'b1;
        default: ;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/decode_issue_stage_reg_file_bypass.sv
// reg_file_bypass: N_REGS x DATA_W register file, two read ports, one write
// port, with write-through: a read of the address being written this cycle
// returns the incoming write data.
// Ports:
//   clk, rst           clock, asynchronous active-low reset (clears all regs)
//   we, waddr, wdata   write port, committed on the rising edge
//   raddr1, rdata1     read port 1 (combinational)
//   raddr2, rdata2     read port 2 (combinational)
module reg_file_bypass #(
  parameter int DATA_W = 16,
  parameter int N_REGS = 8,
  parameter int RA_W   = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [RA_W-1:0]   raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [N_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
  assign rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];

endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: ID stage of the 16-bit RISC pipeline. Decodes one- and
// two-word instructions, reads operands from an internal bypassed register
// file, stalls on load-use hazards and issues a registered ID/EX bundle.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   if_valid, if_inst          fetch word (instruction, or immediate in S_IMM)
//   id_ready                   stage takes if_inst this cycle (combinational)
//   flush                      kill in-flight decode (taken branch)
//   wb_we, wb_addr, wb_data    register-file write port from write-back
//   ex_*                       registered ID/EX bundle
//   dbg_state                  current FSM state (0 = S_DECODE, 1 = S_IMM)
//
// Handshake: a fetch word is consumed on a rising edge exactly when
// if_valid && id_ready. id_ready depends only on state, the current EX bundle,
// if_inst and flush, never on if_valid; fetch must hold if_inst while
// if_valid && !id_ready.
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int INST_W = 16,
  parameter  int N_REGS = 8,
  parameter  int OPC_W  = 5,
  localparam int RA_W   = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_ready,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [OPC_W-1:0]  ex_alu_op,
  output logic              ex_alu_to_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_uses_imm,
  output logic [RA_W-1:0]   ex_rd,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic              dbg_state
);

  // Register fields sit directly below the opcode.
  localparam int RD_LSB  = INST_W - OPC_W - RA_W;
  localparam int RS1_LSB = RD_LSB - RA_W;
  localparam int RS2_LSB = RS1_LSB - RA_W;

  state_e state;

  logic [OPC_W-1:0]  f_opc;
  logic [RA_W-1:0]   f_rd, f_rs1, f_rs2;
  ctrl_t             dec;
  logic              hazard, accept;
  logic [DATA_W-1:0] imm_sext;
  logic [RA_W-1:0]   raddr1, raddr2;
  logic [DATA_W-1:0] rdata1, rdata2;

  // First word of a two-word op, held while waiting for its immediate.
  logic [OPC_W-1:0]  l_opc;
  logic [RA_W-1:0]   l_rd, l_rs1, l_rs2;
  logic              l_alu_to_reg, l_reg_write, l_mem_read, l_mem_write;

  assign f_opc = if_inst[INST_W-1 -: OPC_W];
  assign f_rd  = if_inst[RD_LSB  +: RA_W];
  assign f_rs1 = if_inst[RS1_LSB +: RA_W];
  assign f_rs2 = if_inst[RS2_LSB +: RA_W];
  assign dec   = decode(32'(f_opc));

  assign imm_sext = DATA_W'($signed(if_inst));

  // Load-use: the load now in EX has not produced its data yet. Only a word
  // decoded in S_DECODE is an instruction; in S_IMM it is an immediate.
  assign hazard = (state == S_DECODE) && ex_valid && ex_mem_read &&
                  ((dec.uses_rs1 && (ex_rd == f_rs1)) ||
                   (dec.uses_rs2 && (ex_rd == f_rs2)));

  // Under flush the word is swallowed rather than back-pressured.
  assign id_ready  = !hazard || flush;
  assign accept    = if_valid && id_ready;
  assign dbg_state = (state == S_IMM);

  // Two-word ops read their operands at issue time, from the latched fields.
  assign raddr1 = (state == S_IMM) ? l_rs1 : f_rs1;
  assign raddr2 = (state == S_IMM) ? l_rs2 : f_rs2;

  reg_file_bypass #(
    .DATA_W (DATA_W),
    .N_REGS (N_REGS),
    .RA_W   (RA_W)
  ) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  // FSM, latched first word and ID/EX register. Fields other than ex_valid
  // hold their value on a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_DECODE;
      l_opc         <= '0;
      l_rd          <= '0;
      l_rs1         <= '0;
      l_rs2         <= '0;
      l_alu_to_reg  <= 1'b0;
      l_reg_write   <= 1'b0;
      l_mem_read    <= 1'b0;
      l_mem_write   <= 1'b0;
      ex_valid      <= 1'b0;
      ex_alu_op     <= '0;
      ex_alu_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_uses_imm   <= 1'b0;
      ex_rd         <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rdata1     <= '0;
      ex_rdata2     <= '0;
      ex_imm        <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      state    <= S_DECODE;
    end else begin
      case (state)
        S_DECODE: begin
          if (accept && dec.two_word) begin
            l_opc        <= f_opc;
            l_rd         <= f_rd;
            l_rs1        <= f_rs1;
            l_rs2        <= f_rs2;
            l_alu_to_reg <= dec.alu_to_reg;
            l_reg_write  <= dec.reg_write;
            l_mem_read   <= dec.mem_read;
            l_mem_write  <= dec.mem_write;
            ex_valid     <= 1'b0;
            state        <= S_IMM;
          end else if (accept) begin
            ex_valid      <= 1'b1;
            ex_alu_op     <= f_opc;
            ex_alu_to_reg <= dec.alu_to_reg;
            ex_reg_write  <= dec.reg_write;
            ex_mem_read   <= dec.mem_read;
            ex_mem_write  <= dec.mem_write;
            ex_uses_imm   <= 1'b0;
            ex_rd         <= f_rd;
            ex_rs1        <= f_rs1;
            ex_rs2        <= f_rs2;
            ex_rdata1     <= rdata1;
            ex_rdata2     <= rdata2;
            ex_imm        <= '0;
          end else begin
            ex_valid <= 1'b0;
          end
        end
        S_IMM: begin
          if (accept) begin
            ex_valid      <= 1'b1;
            ex_alu_op     <= l_opc;
            ex_alu_to_reg <= l_alu_to_reg;
            ex_reg_write  <= l_reg_write;
            ex_mem_read   <= l_mem_read;
            ex_mem_write  <= l_mem_write;
            ex_uses_imm   <= 1'b1;
            ex_rd         <= l_rd;
            ex_rs1        <= l_rs1;
            ex_rs2        <= l_rs2;
            ex_rdata1     <= rdata1;
            ex_rdata2     <= rdata2;
            ex_imm        <= imm_sext;
            state         <= S_DECODE;
          end else begin
            ex_valid <= 1'b0;
          end
        end
        default: state <= S_DECODE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Testbench for decode_issue_stage (default parameters: 16-bit data and
// instructions, 8 registers, 5-bit opcode).
// Inputs change 1 time unit after a rising edge; the reference model steps on
// the rising edge and a compare process checks the DUT against it on every
// falling edge. Directed sequences add hand-computed literal checks.
module tb_decode_issue_stage;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_inst;
  logic        id_ready;
  logic        flush;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_valid;
  logic [4:0]  ex_alu_op;
  logic        ex_alu_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_uses_imm;
  logic [2:0]  ex_rd, ex_rs1, ex_rs2;
  logic [15:0] ex_rdata1, ex_rdata2, ex_imm;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  decode_issue_stage dut (
    .clk           (clk),
    .rst           (rst),
    .if_valid      (if_valid),
    .if_inst       (if_inst),
    .id_ready      (id_ready),
    .flush         (flush),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .ex_valid      (ex_valid),
    .ex_alu_op     (ex_alu_op),
    .ex_alu_to_reg (ex_alu_to_reg),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_uses_imm   (ex_uses_imm),
    .ex_rd         (ex_rd),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rdata1     (ex_rdata1),
    .ex_rdata2     (ex_rdata2),
    .ex_imm        (ex_imm),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          valid;
    logic [4:0]  op;
    bit          a2r, rw, mr, mw, ui, u1, u2;
    logic [2:0]  rd, rs1, rs2;
    logic [15:0] d1, d2, imm;
  } bundle_t;

  bundle_t     e;            // bundle expected on the ex_* outputs
  logic [15:0] mregs [8];    // architectural register contents
  logic [15:0] pend_q [$];   // first word of a two-word op awaiting its immediate

  // Opcode table of the ISA: control bits, length and source usage.
  function automatic void op_class(input logic [4:0] op, output bit a2r, output bit rw,
                                   output bit mr, output bit mw, output bit two,
                                   output bit u1, output bit u2);
    a2r = 0; rw = 0; mr = 0; mw = 0; two = 0; u1 = 0; u2 = 0;
    if (op >= 5'd1 && op <= 5'd15) begin
      a2r = 1; rw = 1; u1 = 1; u2 = 1;
    end else if (op == 5'd16) begin
      a2r = 1; rw = 1; two = 1;
    end else if (op == 5'd17) begin
      a2r = 1; rw = 1; u1 = 1; two = 1;
    end else if (op == 5'd18) begin
      mr = 1; rw = 1; u1 = 1; two = 1;
    end else if (op == 5'd19) begin
      mw = 1; u1 = 1; u2 = 1; two = 1;
    end
  endfunction

  function automatic bit two_word(input logic [15:0] w);
    bit a2r, rw, mr, mw, two, u1, u2;
    op_class(w[15:11], a2r, rw, mr, mw, two, u1, u2);
    return two;
  endfunction

  // Register read as EX will see it: a same-cycle write wins.
  function automatic logic [15:0] rd_reg(input logic [2:0] r);
    return (wb_we && wb_addr == r) ? wb_data : mregs[r];
  endfunction

  function automatic bundle_t build(input logic [15:0] w, input bit with_imm,
                                    input logic [15:0] imm);
    bundle_t b;
    bit a2r, rw, mr, mw, two, u1, u2;
    op_class(w[15:11], a2r, rw, mr, mw, two, u1, u2);
    b.valid = 1;
    b.op  = w[15:11];
    b.a2r = a2r; b.rw = rw; b.mr = mr; b.mw = mw; b.u1 = u1; b.u2 = u2;
    b.rd  = w[10:8];
    b.rs1 = w[7:5];
    b.rs2 = w[4:2];
    b.ui  = with_imm;
    b.imm = with_imm ? imm : 16'h0000;
    b.d1  = rd_reg(b.rs1);
    b.d2  = rd_reg(b.rs2);
    return b;
  endfunction

  // The fetch word must wait while a load in EX targets one of its sources.
  function automatic bit model_ready();
    bit a2r, rw, mr, mw, two, u1, u2;
    bit stall;
    op_class(if_inst[15:11], a2r, rw, mr, mw, two, u1, u2);
    stall = (pend_q.size() == 0) && e.valid && e.mr &&
            ((u1 && e.rd == if_inst[7:5]) || (u2 && e.rd == if_inst[4:2]));
    return !stall || flush;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e = '{default: 0};
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
      pend_q.delete();
    end else begin
      logic [15:0] first;
      if (flush) begin
        e.valid = 0;
        pend_q.delete();
      end else if (pend_q.size() != 0) begin
        if (if_valid) begin
          first = pend_q.pop_front();
          e = build(first, 1'b1, if_inst);
        end else begin
          e.valid = 0;
        end
      end else if (if_valid && model_ready()) begin
        if (two_word(if_inst)) begin
          pend_q.push_back(if_inst);
          e.valid = 0;
        end else begin
          e = build(if_inst, 1'b0, 16'h0000);
        end
      end else begin
        e.valid = 0;
      end
      if (wb_we) mregs[wb_addr] = wb_data;
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    check("ex_valid", ex_valid, e.valid);
    check("state", dbg_state, pend_q.size() != 0);
    check("id_ready", id_ready, model_ready());
    if (e.valid) begin
      check("ex_alu_op", ex_alu_op, e.op);
      check("ex_alu_to_reg", ex_alu_to_reg, e.a2r);
      check("ex_reg_write", ex_reg_write, e.rw);
      check("ex_mem_read", ex_mem_read, e.mr);
      check("ex_mem_write", ex_mem_write, e.mw);
      check("ex_uses_imm", ex_uses_imm, e.ui);
      check("ex_rd", ex_rd, e.rd);
      check("ex_rs1", ex_rs1, e.rs1);
      check("ex_rs2", ex_rs2, e.rs2);
      check("ex_imm", ex_imm, e.imm);
      if (e.u1) check("ex_rdata1", ex_rdata1, e.d1);
      if (e.u2) check("ex_rdata2", ex_rdata2, e.d2);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 2'b00};
  endfunction

  task automatic drive(input bit v, input logic [15:0] w, input bit fl = 0,
                       input bit we = 0, input logic [2:0] wa = 0, input logic [15:0] wd = 0);
    if_valid = v;
    if_inst  = w;
    flush    = fl;
    wb_we    = we;
    wb_addr  = wa;
    wb_data  = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit v, input logic [15:0] w, input bit fl = 0,
                     input bit we = 0, input logic [2:0] wa = 0, input logic [15:0] wd = 0);
    drive(v, w, fl, we, wa, wd);
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0;
    drive(0, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_state", dbg_state, 0);
    check("rst_ex_imm", ex_imm, 16'h0000);
    rst = 1'b1;

    // Give EX some state, then reset asynchronously while in S_IMM.
    cyc(0, 16'h0000, 0, 1, 3'd5, 16'hAAAA);
    cyc(1, enc(5'd1, 3'd6, 3'd5, 3'd5));
    check("pre_rst_rdata1", ex_rdata1, 16'hAAAA);
    cyc(1, 16'h8300);
    check("ldm_enters_imm", dbg_state, 1);
    #3 rst = 1'b0;
    #1;
    check("arst_state", dbg_state, 0);
    check("arst_ex_rd", ex_rd, 0);
    check("arst_ex_rdata1", ex_rdata1, 16'h0000);
    check("arst_ex_reg_write", ex_reg_write, 0);
    drive(0, 16'h0000);
    tick();
    rst = 1'b1;

    // All registers read back zero after reset.
    for (int i = 0; i < 8; i++) begin
      cyc(1, enc(5'd1, 3'd0, 3'(i), 3'(i)));
      if (i == 5) check("r5_cleared", ex_rdata1, 16'h0000);
    end

    // Write R1 and issue a reader in the same cycle: bypass.
    cyc(1, enc(5'd2, 3'd2, 3'd1, 3'd1), 0, 1, 3'd1, 16'h1234);
    check("bypass_rdata1", ex_rdata1, 16'h1234);
    check("bypass_rdata2", ex_rdata2, 16'h1234);
    check("bypass_rd", ex_rd, 3'd2);

    // LDM R3, #0xFF80: one bubble then issue with the immediate.
    cyc(1, 16'h8300);
    check("ldm_bubble", ex_valid, 0);
    cyc(1, 16'hFF80);
    check("ldm_valid", ex_valid, 1);
    check("ldm_imm", ex_imm, 16'hFF80);
    check("ldm_rd", ex_rd, 3'd3);
    check("ldm_uses_imm", ex_uses_imm, 1);
    check("ldm_op", ex_alu_op, 5'h10);

    // LDD R4 then ALU reading R4 via rs1: one stall cycle.
    cyc(1, enc(5'd18, 3'd4, 3'd1, 3'd0));
    cyc(1, 16'h0004);
    check("ldd_mem_read", ex_mem_read, 1);
    check("ldd_rdata1", ex_rdata1, 16'h1234);
    drive(1, enc(5'd3, 3'd5, 3'd4, 3'd1));
    #1;
    check("stall_ready", id_ready, 0);
    tick();
    check("stall_bubble", ex_valid, 0);
    check("stall_released", id_ready, 1);
    tick();
    check("after_stall_valid", ex_valid, 1);
    check("after_stall_rs1", ex_rs1, 3'd4);
    check("after_stall_op", ex_alu_op, 5'd3);

    // LDD R2 then STD using R2 as rs2: stall, then the STD completes.
    cyc(1, enc(5'd18, 3'd2, 3'd1, 3'd0));
    cyc(1, 16'hFFFE);
    drive(1, enc(5'd19, 3'd0, 3'd1, 3'd2));
    #1;
    check("stall_rs2_ready", id_ready, 0);
    tick();
    tick();
    check("std_in_imm", dbg_state, 1);
    cyc(1, 16'h0010);
    check("std_mem_write", ex_mem_write, 1);
    check("std_imm", ex_imm, 16'h0010);

    // LDD R3 followed by an op not sourcing R3: no stall.
    cyc(1, enc(5'd18, 3'd3, 3'd1, 3'd0));
    cyc(1, 16'h0001);
    drive(1, enc(5'd4, 3'd3, 3'd1, 3'd2));
    #1;
    check("no_stall_ready", id_ready, 1);
    tick();
    check("no_stall_valid", ex_valid, 1);

    // Flush between the two words of an STD; the word under flush is dropped.
    cyc(1, enc(5'd19, 3'd0, 3'd1, 3'd2));
    check("flush_pre_state", dbg_state, 1);
    cyc(1, 16'h1234, 1);
    check("flush_valid", ex_valid, 0);
    check("flush_state", dbg_state, 0);
    cyc(1, enc(5'd3, 3'd6, 3'd1, 3'd2));
    check("post_flush_valid", ex_valid, 1);
    check("post_flush_op", ex_alu_op, 5'd3);
    check("post_flush_uses_imm", ex_uses_imm, 0);

    // Flush overrides a load-use stall.
    cyc(1, enc(5'd18, 3'd4, 3'd1, 3'd0));
    cyc(1, 16'h0004);
    drive(1, enc(5'd3, 3'd5, 3'd4, 3'd1), 1);
    #1;
    check("flush_ready", id_ready, 1);
    tick();
    check("flush_stall_valid", ex_valid, 0);
    cyc(1, enc(5'd3, 3'd5, 3'd4, 3'd1));
    check("flush_stall_issue", ex_valid, 1);

    // IADD R7 with a 3-cycle fetch gap before its immediate.
    cyc(1, enc(5'd17, 3'd7, 3'd1, 3'd0));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 16'h0000);
      check("gap_valid", ex_valid, 0);
      check("gap_state", dbg_state, 1);
    end
    cyc(1, 16'h0005);
    check("gap_issue_valid", ex_valid, 1);
    check("gap_issue_rdata1", ex_rdata1, 16'h1234);
    check("gap_issue_imm", ex_imm, 16'h0005);

    // Write-back to the latched source in the issue cycle of a two-word op.
    cyc(1, enc(5'd17, 3'd1, 3'd2, 3'd0));
    cyc(1, 16'h8000, 0, 1, 3'd2, 16'h0BCD);
    check("imm_bypass_rdata1", ex_rdata1, 16'h0BCD);
    check("imm_sext_neg", ex_imm, 16'h8000);

    // NOP and an undefined opcode both issue with all control bits clear.
    cyc(1, 16'h0000);
    check("nop_valid", ex_valid, 1);
    check("nop_reg_write", ex_reg_write, 0);
    cyc(1, 16'hF800);
    check("undef_valid", ex_valid, 1);
    check("undef_op", ex_alu_op, 5'h1F);
    check("undef_reg_write", ex_reg_write, 0);
    check("undef_mem_write", ex_mem_write, 0);

    cyc(0, 16'h0000);
    cyc(0, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
